// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the double-buffered frame buffer:
//   - write-FSM state encoding (IDLE = 0, WRITE = 1, DONE = 2)
//   - default stored bits per colour channel
//   - stored word width derivation
// No ports (package).
// ---------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    localparam int c_def_nb_buf_red   = 4;
    localparam int c_def_nb_buf_green = 4;
    localparam int c_def_nb_buf_blue  = 4;

    // Stored word is {R,G,B} packed back to back.
    function automatic int buf_width(input int nb_red, input int nb_green, input int nb_blue);
        return nb_red + nb_green + nb_blue;
    endfunction

    localparam int c_def_nb_buf = buf_width(c_def_nb_buf_red, c_def_nb_buf_green, c_def_nb_buf_blue);

endpackage

// File: rtl/frame_buffer_dbl_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_dbl_if
// Bundles the capture-side write stream, the display-side read port and the
// status outputs of frame_buffer_dbl.
//   wr_sof, wr_valid, wr_data : pixel stream into the back bank
//   rd_addr, rd_frame_end     : display address and vsync pulse
//   rd_data, rd_bank          : registered front-bank pixel, front bank index
//   frame_ready               : a complete frame has been swapped in
//   drop_cnt                  : dropped-frame count (FB_DROP_CNT_EN only)
//   wr_state                  : write-FSM state, for observation
// Modports: master = capture/display side, slave = frame buffer.
// ---------------------------------------------------------------------------
interface frame_buffer_dbl_if
    import fb_pkg::*;
#(
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = c_def_nb_buf
);
    logic                     wr_sof;
    logic                     wr_valid;
    logic [c_nb_buf-1:0]      wr_data;
    logic [c_nb_img_pxls-1:0] rd_addr;
    logic                     rd_frame_end;
    logic [c_nb_buf-1:0]      rd_data;
    logic                     rd_bank;
    logic                     frame_ready;
`ifdef FB_DROP_CNT_EN
    logic [7:0]               drop_cnt;
`endif
    wr_state_t                wr_state;

    modport master (
        output wr_sof, wr_valid, wr_data, rd_addr, rd_frame_end,
`ifdef FB_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  rd_data, rd_bank, frame_ready, wr_state
    );

    modport slave (
        input  wr_sof, wr_valid, wr_data, rd_addr, rd_frame_end,
`ifdef FB_DROP_CNT_EN
        output drop_cnt,
`endif
        output rd_data, rd_bank, frame_ready, wr_state
    );
endinterface

// File: rtl/fb_dp_ram.sv
// ---------------------------------------------------------------------------
// fb_dp_ram
// Simple dual-port RAM: synchronous write on port A, registered read on
// port B. No reset on storage or read register so it maps onto block RAM.
//   clk    : clock
//   we_a   : write enable, addr_a/din_a : write address/data
//   addr_b : read address, dout_b : read data one cycle after addr_b
// ---------------------------------------------------------------------------
module fb_dp_ram #(
    parameter int c_depth   = 16,
    parameter int c_width   = 12,
    parameter int c_nb_addr = $clog2(c_depth)
) (
    input  logic                 clk,
    input  logic                 we_a,
    input  logic [c_nb_addr-1:0] addr_a,
    input  logic [c_width-1:0]   din_a,
    input  logic [c_nb_addr-1:0] addr_b,
    output logic [c_width-1:0]   dout_b
);
    logic [c_width-1:0] mem [c_depth];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    always_ff @(posedge clk) begin
        dout_b <= mem[addr_b];
    end
endmodule

// File: rtl/frame_buffer_dbl.sv
// ---------------------------------------------------------------------------
// frame_buffer_dbl
// Ping-pong frame buffer between camera capture and VGA display. The writer
// fills the back bank through an internal pixel counter; the display reads
// the front bank by address. Banks swap on rd_frame_end only once the back
// bank holds a complete frame, so the display never sees a torn image.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : frame_buffer_dbl_if.slave (write stream, read port, status)
// Optional build macro FB_DROP_CNT_EN adds an 8-bit saturating drop counter
// on bus.drop_cnt.
// ---------------------------------------------------------------------------
module frame_buffer_dbl
    import fb_pkg::*;
#(
    parameter int c_img_cols     = 160,
    parameter int c_img_rows     = 120,
    parameter int c_nb_buf_red   = c_def_nb_buf_red,
    parameter int c_nb_buf_green = c_def_nb_buf_green,
    parameter int c_nb_buf_blue  = c_def_nb_buf_blue
) (
    input logic               clk,
    input logic               rst_n,
    frame_buffer_dbl_if.slave bus
);
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = $clog2(c_img_pxls);
    localparam int c_nb_buf      = buf_width(c_nb_buf_red, c_nb_buf_green, c_nb_buf_blue);
    localparam int c_nb_addr     = c_nb_img_pxls + 1;

    localparam logic [c_nb_img_pxls-1:0] c_last      = c_nb_img_pxls'(c_img_pxls - 1);
    localparam logic [c_nb_img_pxls-1:0] c_one       = c_nb_img_pxls'(1);
    localparam logic [c_nb_addr-1:0]     c_bank1_base = c_nb_addr'(c_img_pxls);

    wr_state_t                state_q, state_d;
    logic [c_nb_img_pxls-1:0] cnt_q, cnt_d;
    logic [c_nb_img_pxls-1:0] we_pix;
    logic                     we, start, swap, drop;
    logic                     wr_bank_q, rd_bank_q, frame_ready_q, rd_ok_q;
    logic                     wr_bank_eff;
    logic [c_nb_addr-1:0]     wr_addr, rd_phys;
    logic [c_nb_buf-1:0]      ram_q;

    // Write stream semantics: wr_valid is a strobe with no backpressure. A
    // pixel is consumed on every cycle wr_valid is high while a frame is being
    // collected; wr_sof marks that cycle's pixel as pixel 0. Pixels outside a
    // frame (IDLE, or DONE waiting for the swap) are silently discarded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        we_pix  = cnt_q;
        start   = 1'b0;
        swap    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            ST_IDLE:  start = bus.wr_sof;
            ST_WRITE: begin
                if (bus.wr_sof) begin
                    start = 1'b1;
                    drop  = 1'b1;   // partial frame abandoned
                end else if (bus.wr_valid) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.rd_frame_end) begin
                    swap  = 1'b1;
                    // A coincident sof begins the next frame in the new back
                    // bank instead of being dropped.
                    start = bus.wr_sof;
                    if (!bus.wr_sof) begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.wr_sof) begin
                    drop = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_WRITE;
            we_pix  = '0;
            we      = bus.wr_valid;
            cnt_d   = bus.wr_valid ? c_one : '0;
        end
        if (we && (we_pix == c_last)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wr_bank_q     <= 1'b1;
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (swap) begin
                rd_bank_q     <= wr_bank_q;
                wr_bank_q     <= ~wr_bank_q;
                frame_ready_q <= 1'b1;
            end
            // Gate tracks the RAM read register, so it uses the pre-swap
            // frame_ready just like the RAM uses the pre-swap bank.
            rd_ok_q <= frame_ready_q && ({1'b0, bus.rd_addr} < c_bank1_base);
        end
    end

    // On a swap cycle the write belongs to the bank that becomes back.
    assign wr_bank_eff = swap ? ~wr_bank_q : wr_bank_q;
    assign wr_addr     = wr_bank_eff ? (c_bank1_base + {1'b0, we_pix}) : {1'b0, we_pix};
    assign rd_phys     = rd_bank_q ? (c_bank1_base + {1'b0, bus.rd_addr}) : {1'b0, bus.rd_addr};

    fb_dp_ram #(
        .c_depth   (2 * c_img_pxls),
        .c_width   (c_nb_buf),
        .c_nb_addr (c_nb_addr)
    ) u_ram (
        .clk    (clk),
        .we_a   (we),
        .addr_a (wr_addr),
        .din_a  (bus.wr_data),
        .addr_b (rd_phys),
        .dout_b (ram_q)
    );

    assign bus.rd_data     = rd_ok_q ? ram_q : '0;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.wr_state    = state_q;

`ifdef FB_DROP_CNT_EN
    logic [7:0] drop_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end
    assign bus.drop_cnt = drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_frame_buffer_dbl.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_dbl
// Bench for frame_buffer_dbl: a 4x2 instance driven by directed and random
// stimulus against a frame-level reference model, plus a 3x3 instance whose
// 4-bit address can reach beyond the image for the out-of-range read.
// ---------------------------------------------------------------------------
module tb_frame_buffer_dbl;
    import fb_pkg::*;

    localparam int N = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_buffer_dbl_if #(.c_nb_img_pxls(3), .c_nb_buf(12)) bus  ();
    frame_buffer_dbl_if #(.c_nb_img_pxls(4), .c_nb_buf(12)) bus9 ();

    frame_buffer_dbl #(.c_img_cols(4), .c_img_rows(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    frame_buffer_dbl #(.c_img_cols(3), .c_img_rows(3)) u_dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus9.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks frames, not FSM states: a queue of pixels being collected, a
    // staged complete frame waiting for vsync, and the image on display.
    logic [11:0] exp_q[$];
    logic [11:0] m_pend[$];
    logic [11:0] m_stage [N];
    logic [11:0] m_front [N];
    bit          m_collect = 0;
    bit          m_full    = 0;
    bit          m_ready   = 0;
    bit          m_bank    = 0;
    int          m_drops   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_collect = 0;
            m_full    = 0;
            m_ready   = 0;
            m_bank    = 0;
            m_drops   = 0;
            m_pend.delete();
            exp_q.delete();
        end else begin
            exp_q.push_back((m_ready && int'(bus.rd_addr) < N) ? m_front[bus.rd_addr] : 12'h000);
            if (m_full && bus.rd_frame_end) begin
                m_front = m_stage;
                m_bank  = !m_bank;
                m_ready = 1;
                m_full  = 0;
            end
            if (bus.wr_sof) begin
                if (m_full || m_collect) begin
                    if (m_drops < 255) m_drops++;
                end
                if (!m_full) begin
                    m_pend.delete();
                    m_collect = 1;
                    if (bus.wr_valid) m_pend.push_back(bus.wr_data);
                end
            end else if (m_collect && bus.wr_valid) begin
                m_pend.push_back(bus.wr_data);
            end
            if (m_collect && m_pend.size() == N) begin
                for (int k = 0; k < N; k++) m_stage[k] = m_pend[k];
                m_full    = 1;
                m_collect = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            chk("rd_bank", 32'(bus.rd_bank), 32'(m_bank));
            chk("frame_ready", 32'(bus.frame_ready), 32'(m_ready));
`ifdef FB_DROP_CNT_EN
            chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic sof, input logic valid, input logic [11:0] data,
                       input logic [2:0] addr, input logic fend);
        bus.wr_sof       = sof;
        bus.wr_valid     = valid;
        bus.wr_data      = data;
        bus.rd_addr      = addr;
        bus.rd_frame_end = fend;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.wr_sof        = 1'b0;
        bus.wr_valid      = 1'b0;
        bus.wr_data       = '0;
        bus.rd_addr       = '0;
        bus.rd_frame_end  = 1'b0;
        bus9.wr_sof       = 1'b0;
        bus9.wr_valid     = 1'b0;
        bus9.wr_data      = '0;
        bus9.rd_addr      = '0;
        bus9.rd_frame_end = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // 1: reset state
        cyc(0, 0, 12'h0, 3'd3, 0);
        chk("t1_rd_data", 32'(bus.rd_data), 32'h0);
        chk("t1_rd_bank", 32'(bus.rd_bank), 32'h0);
        chk("t1_frame_ready", 32'(bus.frame_ready), 32'h0);

        // 2: first frame, swap, read back
        for (int i = 0; i < N; i++) cyc(i == 0, 1, 12'h100 + 12'(i), 3'd0, 0);
        cyc(0, 0, 12'h0, 3'd0, 1);
        chk("t2_rd_bank", 32'(bus.rd_bank), 32'h1);
        chk("t2_frame_ready", 32'(bus.frame_ready), 32'h1);
        cyc(0, 0, 12'h0, 3'd5, 0);
        chk("t2_rd_addr5", 32'(bus.rd_data), 32'h105);

        // 3: second sof while a complete frame waits is dropped
        do_reset();
        for (int i = 0; i < N; i++) cyc(i == 0, 1, 12'h300 + 12'(i), 3'd0, 0);
        for (int i = 0; i < N; i++) cyc(i == 0, 1, 12'h400 + 12'(i), 3'd0, 0);
`ifdef FB_DROP_CNT_EN
        chk("t3_drop_cnt", 32'(bus.drop_cnt), 32'h1);
`endif
        cyc(0, 0, 12'h0, 3'd0, 1);
        cyc(0, 0, 12'h0, 3'd2, 0);
        chk("t3_rd_addr2", 32'(bus.rd_data), 32'h302);
        cyc(0, 0, 12'h0, 3'd0, 0);
        chk("t3_rd_addr0", 32'(bus.rd_data), 32'h300);

        // 4: partial frame restarted by a new sof
        do_reset();
        for (int i = 0; i < 3; i++) cyc(i == 0, 1, 12'h111 + 12'(i), 3'd0, 0);
        for (int i = 0; i < N; i++) cyc(i == 0, 1, 12'h2AA, 3'd0, 0);
`ifdef FB_DROP_CNT_EN
        chk("t4_drop_cnt", 32'(bus.drop_cnt), 32'h1);
`endif
        cyc(0, 0, 12'h0, 3'd0, 1);
        for (int a = 0; a < N; a++) begin
            cyc(0, 0, 12'h0, 3'(a), 0);
            chk("t4_all_2aa", 32'(bus.rd_data), 32'h2AA);
        end

        // 5: vsync and sof together while a complete frame waits
        for (int i = 0; i < N; i++) cyc(i == 0, 1, 12'h500 + 12'(i), 3'd0, 0);
        cyc(1, 1, 12'h5AB, 3'd3, 1);
        chk("t5_old_bank_read", 32'(bus.rd_data), 32'h2AA);
        chk("t5_rd_bank", 32'(bus.rd_bank), 32'h0);
`ifdef FB_DROP_CNT_EN
        chk("t5_drop_cnt", 32'(bus.drop_cnt), 32'h1);
`endif
        for (int i = 1; i < N; i++) begin
            cyc(0, 1, 12'h600 + 12'(i), 3'd3, 0);
            if (i == 1) chk("t5_new_bank_read", 32'(bus.rd_data), 32'h503);
        end
        cyc(0, 0, 12'h0, 3'd0, 1);
        cyc(0, 0, 12'h0, 3'd0, 0);
        chk("t5_px0", 32'(bus.rd_data), 32'h5AB);
        cyc(0, 0, 12'h0, 3'd7, 0);
        chk("t5_px7", 32'(bus.rd_data), 32'h607);
        cyc(0, 0, 12'h0, 3'd0, 0);

        // 6a: out-of-range read on the 3x3 instance
        for (int i = 0; i < 9; i++) begin
            bus9.wr_sof   = (i == 0);
            bus9.wr_valid = 1'b1;
            bus9.wr_data  = 12'h700 + 12'(i);
            @(posedge clk);
            #2;
        end
        bus9.wr_sof       = 1'b0;
        bus9.wr_valid     = 1'b0;
        bus9.rd_frame_end = 1'b1;
        @(posedge clk);
        #2;
        bus9.rd_frame_end = 1'b0;
        bus9.rd_addr = 4'd8;
        @(posedge clk);
        #2;
        chk("t6_addr8", 32'(bus9.rd_data), 32'h708);
        bus9.rd_addr = 4'd9;
        @(posedge clk);
        #2;
        chk("t6_addr9_oor", 32'(bus9.rd_data), 32'h0);
        bus9.rd_addr = 4'd15;
        @(posedge clk);
        #2;
        chk("t6_addr15_oor", 32'(bus9.rd_data), 32'h0);

        // 6b: asynchronous reset in the middle of a frame
        cyc(1, 1, 12'h777, 3'd0, 0);
        cyc(0, 1, 12'h778, 3'd0, 0);
        chk("t6_pre_ready", 32'(bus.frame_ready), 32'h1);
        chk("t6_pre_data", 32'(bus.rd_data), 32'h5AB);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("t6_rst_rd_bank", 32'(bus.rd_bank), 32'h0);
        chk("t6_rst_frame_ready", 32'(bus.frame_ready), 32'h0);
        chk("t6_rst_wr_state", 32'(bus.wr_state), 32'(ST_IDLE));
`ifdef FB_DROP_CNT_EN
        chk("t6_rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
`endif

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 12'($urandom),
                3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
        end
        cyc(0, 0, 12'h0, 3'd0, 0);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
